// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, step encodings,
// bus source codes and the per-step control decode.
package alu_sequencer_pkg;

    // Instruction opcodes (din[8:6])
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ADDC = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;

    // Bus source codes beyond R0-R7
    localparam logic [3:0] SEL_DIN = 4'd8;
    localparam logic [3:0] SEL_G   = 4'd9;

    // Instruction steps; T0 is idle / fetch
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // Control word held in registers for the current step.
    // r_we is the register-file write term; the target comes from ir X.
    typedef struct packed {
        logic [3:0] bus_sel;
        logic       r_we;
        logic       a_in;
        logic       g_in;
        logic       add_sub;
        logic       cin;
        logic       done;
        logic       illegal;
    } ctrl_t;

    // True for the four opcodes that go through A, the ALU and G
    function automatic logic is_alu_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_ADDC, OP_CMP: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the opcodes that subtract (invert operand, carry in of 1)
    function automatic logic is_sub_op(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

    // Control outputs for a given step, instruction and carry flag.
    // Every signal not named for a step stays 0 (bus_sel included).
    function automatic ctrl_t decode_ctrl(input state_t     st,
                                          input logic [8:0] ir,
                                          input logic       carry);
        ctrl_t      c;
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        op = ir[8:6];
        x  = ir[5:3];
        y  = ir[2:0];
        c  = '0;
        case (st)
            T1: begin
                case (op)
                    OP_MV: begin
                        c.bus_sel = {1'b0, y};
                        c.r_we    = 1'b1;
                        c.done    = 1'b1;
                    end
                    OP_MVI: begin
                        c.bus_sel = SEL_DIN;
                        c.r_we    = 1'b1;
                        c.done    = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_ADDC, OP_CMP: begin
                        c.bus_sel = {1'b0, x};
                        c.a_in    = 1'b1;
                    end
                    default: begin
                        c.done    = 1'b1;
                        c.illegal = 1'b1;
                    end
                endcase
            end
            T2: begin
                c.bus_sel = {1'b0, y};
                c.g_in    = 1'b1;
                c.add_sub = is_sub_op(op);
                c.cin     = is_sub_op(op) | ((op == OP_ADDC) & carry);
            end
            T3: begin
                c.done = 1'b1;
                // cmp only updates flags; the result in G is discarded
                if (op != OP_CMP) begin
                    c.bus_sel = SEL_G;
                    c.r_we    = 1'b1;
                end
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer_reg_select_decoder.sv
// 3-to-8 one-hot decoder with enable; selects which of R0-R7 loads.
module alu_sequencer_reg_select_decoder (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);

    // One bit set for the selected register, all zero when disabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the R0-R7 / A / G / add-sub datapath.
// Fetches a 9-bit instruction IIIXXXYYY in T0 and steps through T1-T3,
// driving bus select, register loads and ALU control from registers.
// Handshake: run is sampled only on a rising edge in T0; when high, din is
// captured and the instruction starts. done pulses for exactly one cycle in
// the last step of each accepted instruction; run seen outside T0 is dropped.
module alu_sequencer #(
    parameter int n = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         run,
    input  logic [8:0]   din,
    input  logic [n-1:0] alu_sum,
    input  logic         alu_cout,
    input  logic         alu_overflow,
    output logic [7:0]   r_in,
    output logic         a_in,
    output logic         g_in,
    output logic [3:0]   bus_sel,
    output logic         add_sub_control,
    output logic         alu_cin,
    output logic         done,
    output logic         illegal,
    output logic         carry_flag,
    output logic         overflow_flag,
    output logic         zero_flag
);

    import alu_sequencer_pkg::*;

    // Current step and latched instruction; state is the observable FSM step
    state_t     state;
    state_t     state_nxt;
    logic [8:0] ir;
    logic [8:0] ir_nxt;

    logic       carry_nxt;
    logic       overflow_nxt;
    logic       zero_nxt;

    ctrl_t      ctrl_q;
    ctrl_t      ctrl_nxt;

    logic       r_we_gated;

    // Next step, next instruction, next flags, and the control word for the next step
    always_comb begin
        state_nxt    = state;
        ir_nxt       = ir;
        carry_nxt    = carry_flag;
        overflow_nxt = overflow_flag;
        zero_nxt     = zero_flag;
        case (state)
            T0: begin
                if (run) begin
                    ir_nxt    = din;
                    state_nxt = T1;
                end
            end
            T1: begin
                state_nxt = is_alu_op(ir[8:6]) ? T2 : T0;
            end
            T2: begin
                // Only ALU opcodes reach T2, so the flags always latch here
                state_nxt    = T3;
                carry_nxt    = alu_cout;
                overflow_nxt = alu_overflow;
                zero_nxt     = (alu_sum == '0);
            end
            T3: begin
                state_nxt = T0;
            end
            default: begin
                state_nxt = T0;
            end
        endcase
        ctrl_nxt = decode_ctrl(state_nxt, ir_nxt, carry_nxt);
    end

    // Step, instruction, flag and registered-control state
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= T0;
            ir            <= '0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            zero_flag     <= 1'b0;
            ctrl_q        <= '0;
        end else begin
            state         <= state_nxt;
            ir            <= ir_nxt;
            carry_flag    <= carry_nxt;
            overflow_flag <= overflow_nxt;
            zero_flag     <= zero_nxt;
            ctrl_q        <= ctrl_nxt;
        end
    end

    // Load enables are masked while reset is high so an instruction cut off
    // mid-step cannot write A, G or the register file during the reset cycle.
    assign r_we_gated      = ctrl_q.r_we & ~reset;
    assign a_in            = ctrl_q.a_in & ~reset;
    assign g_in            = ctrl_q.g_in & ~reset;
    assign bus_sel         = ctrl_q.bus_sel;
    assign add_sub_control = ctrl_q.add_sub;
    assign alu_cin         = ctrl_q.cin;
    assign done            = ctrl_q.done;
    assign illegal         = ctrl_q.illegal;

    alu_sequencer_reg_select_decoder u_reg_select (
        .sel    (ir[5:3]),
        .en     (r_we_gated),
        .onehot (r_in)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, hand-written corner
// sequences, then random instructions against an instruction-level model.
module tb_alu_sequencer;

    localparam int N  = 8;
    localparam int CW = 18;

    logic         clock = 1'b0;
    logic         reset;
    logic         run;
    logic [8:0]   din;
    logic [N-1:0] alu_sum;
    logic         alu_cout;
    logic         alu_overflow;
    logic [7:0]   r_in;
    logic         a_in;
    logic         g_in;
    logic [3:0]   bus_sel;
    logic         add_sub_control;
    logic         alu_cin;
    logic         done;
    logic         illegal;
    logic         carry_flag;
    logic         overflow_flag;
    logic         zero_flag;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle control words; latch_q marks cycles whose ALU inputs set the flags
    logic [CW-1:0] exp_q[$];
    logic          latch_q[$];
    logic          m_c;
    logic          m_v;
    logic          m_z;

    typedef struct {
        string      name;
        logic [8:0] din;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         lat;
        logic       t2_asc;
        logic       t2_cin;
        logic [7:0] r_in;
        logic [3:0] bus;
        logic       ill;
        logic [2:0] flags;
    } vec_t;

    vec_t vecs[11];

    alu_sequencer #(.n(N)) dut (
        .clock           (clock),
        .reset           (reset),
        .run             (run),
        .din             (din),
        .alu_sum         (alu_sum),
        .alu_cout        (alu_cout),
        .alu_overflow    (alu_overflow),
        .r_in            (r_in),
        .a_in            (a_in),
        .g_in            (g_in),
        .bus_sel         (bus_sel),
        .add_sub_control (add_sub_control),
        .alu_cin         (alu_cin),
        .done            (done),
        .illegal         (illegal),
        .carry_flag      (carry_flag),
        .overflow_flag   (overflow_flag),
        .zero_flag       (zero_flag)
    );

    // Clock
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [CW-1:0] mk_ctl(input logic [7:0] r, input logic a, input logic g,
                                             input logic [3:0] bus, input logic asc, input logic cin,
                                             input logic dn, input logic ill);
        return {r, a, g, bus, asc, cin, dn, ill};
    endfunction

    function automatic logic [CW-1:0] cur_ctl();
        return {r_in, a_in, g_in, bus_sel, add_sub_control, alu_cin, done, illegal};
    endfunction

    // Instruction-level model: what each cycle of an instruction should drive
    task automatic model_expect(input logic [8:0] instr);
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] onehot;
        logic       sub;
        logic       cin;
        op     = instr[8:6];
        x      = instr[5:3];
        y      = instr[2:0];
        onehot = 8'b1 << x;
        sub    = (op == 3'd3) || (op == 3'd5);
        cin    = sub ? 1'b1 : ((op == 3'd4) ? m_c : 1'b0);
        case (op)
            3'd0: begin
                exp_q.push_back(mk_ctl(onehot, 0, 0, {1'b0, y}, 0, 0, 1, 0));
                latch_q.push_back(1'b0);
            end
            3'd1: begin
                exp_q.push_back(mk_ctl(onehot, 0, 0, 4'd8, 0, 0, 1, 0));
                latch_q.push_back(1'b0);
            end
            3'd2, 3'd3, 3'd4, 3'd5: begin
                exp_q.push_back(mk_ctl(8'h00, 1, 0, {1'b0, x}, 0, 0, 0, 0));
                latch_q.push_back(1'b0);
                exp_q.push_back(mk_ctl(8'h00, 0, 1, {1'b0, y}, sub, cin, 0, 0));
                latch_q.push_back(1'b1);
                if (op == 3'd5) exp_q.push_back(mk_ctl(8'h00, 0, 0, 4'd0, 0, 0, 1, 0));
                else            exp_q.push_back(mk_ctl(onehot, 0, 0, 4'd9, 0, 0, 1, 0));
                latch_q.push_back(1'b0);
            end
            default: begin
                exp_q.push_back(mk_ctl(8'h00, 0, 0, 4'd0, 0, 0, 1, 1));
                latch_q.push_back(1'b0);
            end
        endcase
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [8:0] instr;
        logic [CW-1:0] e;
        logic l;

        vecs[0]  = '{"mvi_r3",   9'b001_011_000, 8'h00, 1'b1, 1'b1, 2, 1'b0, 1'b0, 8'h08, 4'd8, 1'b0, 3'b000};
        vecs[1]  = '{"add_r1r2", 9'b010_001_010, 8'h00, 1'b1, 1'b0, 4, 1'b0, 1'b0, 8'h02, 4'd9, 1'b0, 3'b101};
        vecs[2]  = '{"addc_c1",  9'b100_001_010, 8'h05, 1'b0, 1'b0, 4, 1'b0, 1'b1, 8'h02, 4'd9, 1'b0, 3'b000};
        vecs[3]  = '{"cmp_r3r4", 9'b101_011_100, 8'h80, 1'b0, 1'b1, 4, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0, 3'b010};
        vecs[4]  = '{"sub_r5r6", 9'b011_101_110, 8'h01, 1'b1, 1'b0, 4, 1'b1, 1'b1, 8'h20, 4'd9, 1'b0, 3'b100};
        vecs[5]  = '{"mv_r7r0",  9'b000_111_000, 8'h00, 1'b0, 1'b1, 2, 1'b0, 1'b0, 8'h80, 4'd0, 1'b0, 3'b100};
        vecs[6]  = '{"ill_110",  9'b110_010_010, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 3'b100};
        vecs[7]  = '{"addc_r0",  9'b100_000_000, 8'h00, 1'b0, 1'b0, 4, 1'b0, 1'b1, 8'h01, 4'd9, 1'b0, 3'b001};
        vecs[8]  = '{"add_r6r7", 9'b010_110_111, 8'hff, 1'b0, 1'b1, 4, 1'b0, 1'b0, 8'h40, 4'd9, 1'b0, 3'b010};
        vecs[9]  = '{"addc_c0",  9'b100_010_011, 8'h7f, 1'b1, 1'b0, 4, 1'b0, 1'b0, 8'h04, 4'd9, 1'b0, 3'b100};
        vecs[10] = '{"ill_111",  9'b111_101_101, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 3'b100};

        // Reset
        reset = 1'b1; run = 1'b0; din = '0;
        alu_sum = '0; alu_cout = 1'b0; alu_overflow = 1'b0;
        step(); step();
        check("reset_ctl", 32'(cur_ctl()), 32'(0));
        check("reset_flags", {29'b0, carry_flag, overflow_flag, zero_flag}, 32'(0));
        reset = 1'b0;
        step();
        check("idle_ctl", 32'(cur_ctl()), 32'(0));

        // Directed vector table
        foreach (vecs[k]) begin
            alu_sum = vecs[k].sum; alu_cout = vecs[k].cout; alu_overflow = vecs[k].ovf;
            run = 1'b1; din = vecs[k].din;
            step();
            run = 1'b0;
            cyc = 1;
            while (done !== 1'b1 && cyc < 8) begin
                if (cyc == 2) check({vecs[k].name, "_t2_alu"}, {30'b0, add_sub_control, alu_cin},
                                    {30'b0, vecs[k].t2_asc, vecs[k].t2_cin});
                step();
                cyc++;
            end
            check({vecs[k].name, "_latency"}, 32'(cyc + 1), 32'(vecs[k].lat));
            check({vecs[k].name, "_done_outs"}, {19'b0, r_in, bus_sel, illegal},
                  {19'b0, vecs[k].r_in, vecs[k].bus, vecs[k].ill});
            check({vecs[k].name, "_flags"}, {29'b0, carry_flag, overflow_flag, zero_flag},
                  {29'b0, vecs[k].flags});
            step();
        end

        // Illegal with run held, then an add with run toggled late: one done per accepted run
        run = 1'b1; din = 9'b111_000_000;
        step();
        check("ill_held_t1", 32'(cur_ctl()), 32'(mk_ctl(8'h00, 0, 0, 4'd0, 0, 0, 1, 1)));
        check("ill_held_flags", {29'b0, carry_flag, overflow_flag, zero_flag}, 32'b100);
        din = 9'b010_001_010;
        step();
        check("held_t0_gap", 32'(cur_ctl()), 32'(0));
        alu_sum = 8'h03; alu_cout = 1'b0; alu_overflow = 1'b0;
        step();
        check("held_add_t1", 32'(cur_ctl()), 32'(mk_ctl(8'h00, 1, 0, 4'd1, 0, 0, 0, 0)));
        ndone = (done === 1'b1) ? 1 : 0;
        din = 9'b000_000_000;
        step();
        run = 1'b0; #1; run = 1'b1; #1; run = 1'b0; #1; run = 1'b1;
        ndone += (done === 1'b1) ? 1 : 0;
        step();
        run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ndone += (done === 1'b1) ? 1 : 0;
            step();
        end
        check("toggle_one_done", 32'(ndone), 32'(1));
        check("toggle_flags", {29'b0, carry_flag, overflow_flag, zero_flag}, 32'b000);

        // Reset in T2 of an add after flags were set
        alu_sum = 8'h00; alu_cout = 1'b1; alu_overflow = 1'b1;
        run = 1'b1; din = 9'b010_001_010;
        step(); run = 1'b0; step(); step(); step();
        check("pre_reset_flags", {29'b0, carry_flag, overflow_flag, zero_flag}, 32'b111);
        run = 1'b1; din = 9'b010_001_010;
        step(); run = 1'b0; step();
        check("pre_reset_t2", 32'(cur_ctl()), 32'(mk_ctl(8'h00, 0, 1, 4'd2, 0, 0, 0, 0)));
        reset = 1'b1;
        step();
        check("midop_reset_ctl", 32'(cur_ctl()), 32'(0));
        check("midop_reset_flags", {29'b0, carry_flag, overflow_flag, zero_flag}, 32'(0));
        reset = 1'b0;
        step();
        check("post_reset_ctl", 32'(cur_ctl()), 32'(0));
        check("post_reset_flags", {29'b0, carry_flag, overflow_flag, zero_flag}, 32'(0));
        run = 1'b1; din = 9'b001_011_000;
        step();
        check("post_reset_mvi", 32'(cur_ctl()), 32'(mk_ctl(8'h08, 0, 0, 4'd8, 0, 0, 1, 0)));
        run = 1'b0;
        step();
        check("post_reset_idle", 32'(cur_ctl()), 32'(0));

        // Random instructions against the model; flags start cleared by the reset above
        m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                check("rand_idle", 32'(cur_ctl()), 32'(0));
                run = 1'b0; din = 9'($urandom);
                step();
            end
            instr = 9'($urandom_range(0, 511));
            model_expect(instr);
            run = 1'b1; din = instr;
            step();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                l = latch_q.pop_front();
                check("rand_ctl", 32'(cur_ctl()), 32'(e));
                check("rand_flags", {29'b0, carry_flag, overflow_flag, zero_flag}, {29'b0, m_c, m_v, m_z});
                alu_sum      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                alu_cout     = 1'($urandom_range(0, 1));
                alu_overflow = 1'($urandom_range(0, 1));
                run          = 1'($urandom_range(0, 1));
                din          = 9'($urandom);
                if (l) begin
                    m_c = alu_cout;
                    m_v = alu_overflow;
                    m_z = (alu_sum == 8'h00);
                end
                step();
            end
        end
        check("rand_end_idle", 32'(cur_ctl()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control FSM for the processor datapath: register file R0-R7, accumulator A, result register G, and the ripple-carry add/sub ALU.
- Captures a 9-bit instruction and drives bus-select, register-load and ALU-control signals over up to four steps (T0-T3).
- Latches carry, overflow and zero flags from ALU outputs; asserts done at completion.
- Control-only: the register file, A, G and the ALU are outside this block.

Parameters:
- n, 8, datapath width; sets alu_sum width.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- run  input  1  start request, sampled only in T0
- din  input  9  instruction word IIIXXXYYY, sampled in T0 when run=1; also the mvi immediate path into the datapath
- alu_sum  input  n  ALU sum output
- alu_cout  input  1  ALU carry out
- alu_overflow  input  1  ALU overflow
- r_in  output  8  one-hot register load enable for R0-R7
- a_in  output  1  load A from bus
- g_in  output  1  load G from ALU sum
- bus_sel  output  4  bus source: 0-7 = R0-R7, 8 = din, 9 = G
- add_sub_control  output  1  ALU operand-invert control (1 = subtract)
- alu_cin  output  1  ALU carry in
- done  output  1  one-cycle completion pulse
- illegal  output  1  one-cycle pulse with done for undefined opcode
- carry_flag  output  1  latched C
- overflow_flag  output  1  latched V
- zero_flag  output  1  latched Z

Behaviour:
- Opcodes (III):
  - 000 mv Rx,Ry
  - 001 mvi Rx,#din
  - 010 add
  - 011 sub
  - 100 addc (add with carry flag)
  - 101 cmp (sub, flags only)
  - 110/111 illegal
- State and outputs:
  - States T0 (idle), T1, T2, T3; two-bit encoding.
  - Internal ir register, 9 bits.
  - All outputs are Moore/decoded from state and ir; every control output is 0 (bus_sel=0) unless listed below.
- Reset (any state, mid-instruction included):
  - Next state T0; ir=0; all flags 0.
  - No r_in/g_in/a_in asserted in the reset cycle or the cycle after.
- T0:
  - If run=1, ir<=din and go to T1; otherwise stay.
  - run is ignored in T1-T3 and is not queued.
- T1:
  - mv: bus_sel=Y, r_in[X]=1, done=1, go to T0.
  - mvi: bus_sel=8, r_in[X]=1, done=1, go to T0.
  - add/sub/addc/cmp: bus_sel=X, a_in=1, go to T2.
  - illegal: done=1, illegal=1, no loads, go to T0.
- T2:
  - bus_sel=Y, g_in=1.
  - add_sub_control=1 for sub/cmp, else 0.
  - alu_cin: 1 for sub/cmp, carry_flag for addc, 0 for add.
  - At the clock edge: carry_flag<=alu_cout, overflow_flag<=alu_overflow, zero_flag<=(alu_sum==0). Go to T3.
- T3:
  - add/sub/addc: bus_sel=9, r_in[X]=1, done=1.
  - cmp: done=1 only.
  - Go to T0.
- Latency: mv/mvi/illegal complete in 2 cycles from run; ALU ops complete in 4 cycles.
- Back-to-back: run held high gives a new fetch in the T0 cycle after done, with no bubble beyond T0.
- Flags change only at the T2 edge of add/sub/addc/cmp; they hold through mv/mvi/illegal.
- X=Y is legal; no hazard handling is needed because transfers are sequential.
- r_in is always one-hot or zero.

Decomposition:
- Shared package holds:
  - opcode constants (OP_MV ... OP_CMP)
  - state encodings T0-T3
  - bus_sel codes (SEL_DIN=8, SEL_G=9)
- One sub-module: reg_select_decoder, a 3-to-8 one-hot decoder with enable, driving r_in from ir X and the write-enable term.

Test Plan:
- Reset mid-op: reset asserted in T2 of add. Next cycle state=T0, outputs all 0, flags 0. Then run with mvi → completes normally.
- mvi: din=9'b001_011_000, run=1. T1: bus_sel=8, r_in=8'b0000_1000, done=1. Next cycle idle.
- add R1,R2 with alu_sum=8'h00, alu_cout=1, alu_overflow=0 in T2:
  - T1: a_in, bus_sel=1.
  - T2: g_in, bus_sel=2, add_sub_control=0, alu_cin=0.
  - T3: bus_sel=9, r_in=8'h02, done.
  - Flags C=1, V=0, Z=1.
- addc after the previous test: T2 alu_cin=1.
- cmp R3,R4: add_sub_control=1, alu_cin=1. T3 has done with r_in=0. Flags updated from inputs (sum 8'h80, overflow 1 → V=1, Z=0).
- Illegal plus run held: din=9'b111_000_000. T1 done=illegal=1, no loads, flags unchanged. run toggled during T2 of a following add has no effect (exactly one done per accepted run).
